// File: rtl/tt_sweep_ctrl_pkg.sv
// Shared types and helpers for the truth-table sweep controller.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tt_state_e;

    localparam int N_IN_DEF = 7;
    localparam int LAT_DEF  = 0;

    // Truth table width for an n-input function.
    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// Harness / function-block bundle for the sweep controller.
interface tt_sweep_ctrl_if
    import tt_pkg::*;
#(
    parameter int N_IN = N_IN_DEF
);
    localparam int TT_W = tt_width(N_IN);

    logic              start;
    logic              abort;
    logic [TT_W-1:0]   expected;
    logic [N_IN-1:0]   x;
    logic              f_in;
    logic              busy;
    logic              done;
    logic              match;
    logic              mis_valid;
    logic [N_IN-1:0]   mis_idx;
    logic [TT_W-1:0]   tt;

    // Controller side.
    modport slave (
        input  start, abort, expected, f_in,
        output x, busy, done, match, mis_valid, mis_idx, tt
    );

    // Harness / function-block side.
    modport master (
        output start, abort, expected, f_in,
        input  x, busy, done, match, mis_valid, mis_idx, tt
    );
endinterface

// File: rtl/tt_sweep_ctrl_idx_pipe.sv
// Delays {valid, idx} by LAT cycles so each sample lines up with the
// function output produced for that minterm.
module tt_idx_pipe #(
    parameter int N_IN = 7,
    parameter int LAT  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    input  logic [N_IN-1:0] i_idx,
    output logic            o_valid,
    output logic [N_IN-1:0] o_idx
);
    generate
        if (LAT == 0) begin : g_pass
            logic w_unused;
            assign w_unused = clk ^ rst_n;
            assign o_valid  = i_valid & ~i_flush;
            assign o_idx    = i_idx;
        end else begin : g_pipe
            logic [N_IN:0] r_sr [LAT];

            // Shift register; flush drops every in-flight sample.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) r_sr[i] <= '0;
                end else if (i_flush) begin
                    for (int i = 0; i < LAT; i++) r_sr[i] <= '0;
                end else begin
                    r_sr[0] <= {i_valid, i_idx};
                    for (int i = 1; i < LAT; i++) r_sr[i] <= r_sr[i-1];
                end
            end

            assign o_valid = r_sr[LAT-1][N_IN];
            assign o_idx   = r_sr[LAT-1][N_IN-1:0];
        end
    endgenerate
endmodule

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep sequencer: walks all minterms onto x, samples f_in,
// and compares the captured table against the expected signature.
//
// state | meaning
// IDLE  | waiting for start, results cleared
// SWEEP | driving minterms 0..TT_W-1 on x
// DRAIN | waiting LAT cycles for the last samples to arrive
// DONE  | results valid; a new start re-arms
module tt_sweep_ctrl
    import tt_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int LAT  = LAT_DEF
) (
    input logic           clk,
    input logic           rst_n,
    tt_sweep_ctrl_if.slave bus
);
    localparam int TT_W = tt_width(N_IN);
    localparam logic [N_IN:0] CNT_LAST  = (N_IN+1)'(TT_W - 1);
    localparam logic [3:0]    DRAIN_LD  = 4'((LAT > 0) ? LAT - 1 : 0);

    tt_state_e        r_state;
    logic [N_IN:0]    r_cnt;
    logic [3:0]       r_drain;
    logic [TT_W-1:0]  r_exp;
    logic [TT_W-1:0]  r_tt;
    logic             r_busy;
    logic             r_done;
    logic             r_match;
    logic             r_mis_valid;
    logic [N_IN-1:0]  r_mis_idx;

    logic             w_start_acc;
    logic             w_abort_acc;
    logic             w_smp_valid;
    logic [N_IN-1:0]  w_smp_idx;
    logic             w_smp_en;
    logic             w_bit_diff;
    logic [TT_W-1:0]  w_tt_next;

    assign w_start_acc = bus.start && (r_state == IDLE || r_state == DONE);
    assign w_abort_acc = bus.abort && (r_state == SWEEP || r_state == DRAIN);

    tt_idx_pipe #(.N_IN(N_IN), .LAT(LAT)) u_idx_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_start_acc | w_abort_acc),
        .i_valid (r_state == SWEEP),
        .i_idx   (r_cnt[N_IN-1:0]),
        .o_valid (w_smp_valid),
        .o_idx   (w_smp_idx)
    );

    assign w_smp_en   = w_smp_valid && (r_state == SWEEP || r_state == DRAIN);
    assign w_bit_diff = bus.f_in != r_exp[w_smp_idx];

    // Truth table including this cycle's sample, so match can be taken on the DONE edge.
    always_comb begin
        w_tt_next = r_tt;
        if (w_smp_en) w_tt_next[w_smp_idx] = bus.f_in;
    end

    // Sequencer FSM with counter, capture and compare registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_drain     <= '0;
            r_exp       <= '0;
            r_tt        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_match     <= 1'b0;
            r_mis_valid <= 1'b0;
            r_mis_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_smp_en) begin
                r_tt <= w_tt_next;
                if (w_bit_diff && !r_mis_valid) begin
                    r_mis_valid <= 1'b1;
                    r_mis_idx   <= w_smp_idx;
                end
            end
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state     <= SWEEP;
                        r_exp       <= bus.expected;
                        r_tt        <= '0;
                        r_match     <= 1'b0;
                        r_mis_valid <= 1'b0;
                        r_mis_idx   <= '0;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                SWEEP, DRAIN: begin
                    if (bus.abort) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_tt        <= '0;
                        r_match     <= 1'b0;
                        r_mis_valid <= 1'b0;
                        r_mis_idx   <= '0;
                        r_busy      <= 1'b0;
                    end else if (r_state == SWEEP && r_cnt != CNT_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (r_state == SWEEP && LAT > 0) begin
                        r_state <= DRAIN;
                        r_drain <= DRAIN_LD;
                    end else if (r_state == DRAIN && r_drain != '0) begin
                        r_drain <= r_drain - 1'b1;
                    end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_match <= (w_tt_next == r_exp);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.x         = r_cnt[N_IN-1:0];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.match     = r_match;
    assign bus.mis_valid = r_mis_valid;
    assign bus.mis_idx   = r_mis_idx;
    assign bus.tt        = r_tt;
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench: u0 is a LAT=0 instance with f = x0&x1, u1 is LAT=2 with
// the same function registered twice.
module tb_tt_sweep_ctrl;
    import tt_pkg::*;

    localparam int N = 7;
    localparam int W = 128;

    typedef struct {
        int         cyc;
        logic       m;
        logic       mv;
        logic [6:0] mi;
        logic [W-1:0] tt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   c0 = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [6:0] xs[$];
    logic f_d1, f_d2;

    localparam logic [W-1:0] PAT = {32{4'h8}};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tt_sweep_ctrl_if #(.N_IN(N)) b0();
    tt_sweep_ctrl_if #(.N_IN(N)) b1();

    tt_sweep_ctrl #(.N_IN(N), .LAT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    tt_sweep_ctrl #(.N_IN(N), .LAT(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    assign b0.f_in = b0.x[0] & b0.x[1];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_d1 <= 1'b0;
            f_d2 <= 1'b0;
        end else begin
            f_d1 <= b1.x[0] & b1.x[1];
            f_d2 <= f_d1;
        end
    end
    assign b1.f_in = f_d2;

    function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    function automatic void cmp_res(string t, exp_t e, int c, logic m, logic mv,
                                    logic [6:0] mi, logic [W-1:0] tt);
        chk({t, "_done_cyc"}, W'(c), W'(e.cyc));
        chk({t, "_match"}, W'(m), W'(e.m));
        chk({t, "_mis_valid"}, W'(mv), W'(e.mv));
        chk({t, "_mis_idx"}, W'(mi), W'(e.mi));
        chk({t, "_tt"}, tt, e.tt);
    endfunction

    // Monitor: pop and compare whenever a DUT pulses done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (b0.done) begin
                if (q0.size() == 0) chk("d0_unexpected_done", 1, 0);
                else cmp_res("d0", q0.pop_front(), cyc, b0.match, b0.mis_valid, b0.mis_idx, b0.tt);
            end
            if (b1.done) begin
                if (q1.size() == 0) chk("d1_unexpected_done", 1, 0);
                else cmp_res("d1", q1.pop_front(), cyc, b1.match, b1.mis_valid, b1.mis_idx, b1.tt);
            end
            if (b1.busy) xs.push_back(b1.x);
        end
    end

    task automatic check_reset(string t, logic [6:0] x, logic busy, logic done, logic m,
                               logic mv, logic [6:0] mi, logic [W-1:0] tt);
        chk({t, "_rst_x"}, W'(x), 0);
        chk({t, "_rst_busy"}, W'(busy), 0);
        chk({t, "_rst_done"}, W'(done), 0);
        chk({t, "_rst_match"}, W'(m), 0);
        chk({t, "_rst_mis_valid"}, W'(mv), 0);
        chk({t, "_rst_mis_idx"}, W'(mi), 0);
        chk({t, "_rst_tt"}, tt, 0);
    endtask

    // Pulse start for one cycle from the current point; optionally push the expected result.
    task automatic start0(input logic [W-1:0] e, input bit push, input logic m,
                          input logic mv, input logic [6:0] mi);
        exp_t x;
        b0.expected = e;
        b0.start = 1'b1;
        c0 = cyc;
        if (push) begin
            x.cyc = cyc + 129; x.m = m; x.mv = mv; x.mi = mi; x.tt = PAT;
            q0.push_back(x);
        end
        @(posedge clk); #1;
        b0.start = 1'b0;
    endtask

    task automatic start1(input logic [W-1:0] e, input logic m, input logic mv,
                          input logic [6:0] mi);
        exp_t x;
        b1.expected = e;
        b1.start = 1'b1;
        x.cyc = cyc + 131; x.m = m; x.mv = mv; x.mi = mi; x.tt = PAT;
        q1.push_back(x);
        @(posedge clk); #1;
        b1.start = 1'b0;
    endtask

    task automatic wait_done0(input int maxc);
        int k = 0;
        while (!b0.done && k < maxc) begin @(negedge clk); k++; end
        if (!b0.done) chk("d0_done_timeout", 0, 1);
    endtask

    task automatic wait_done1(input int maxc);
        int k = 0;
        while (!b1.done && k < maxc) begin @(negedge clk); k++; end
        if (!b1.done) chk("d1_done_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbad;
        b0.start = 0; b0.abort = 0; b0.expected = '0;
        b1.start = 0; b1.abort = 0; b1.expected = '0;
        repeat (3) @(posedge clk); #1;
        check_reset("d0", b0.x, b0.busy, b0.done, b0.match, b0.mis_valid, b0.mis_idx, b0.tt);
        check_reset("d1", b1.x, b1.busy, b1.done, b1.match, b1.mis_valid, b1.mis_idx, b1.tt);
        rst_n = 1'b1;

        // Matching sweep; expected scrambled after capture must not matter.
        @(posedge clk); #1;
        start0(PAT, 1, 1, 0, 0);
        b0.expected = ~PAT;
        wait_done0(300);

        // Bits 5 and 9 flipped.
        @(posedge clk); #1;
        start0(PAT ^ (W'(1) << 5) ^ (W'(1) << 9), 1, 0, 1, 7'd5);
        wait_done0(300);

        // Restart on the done cycle: old results cleared the next cycle.
        start0(PAT, 1, 1, 0, 0);
        chk("d0_restart_busy", W'(b0.busy), 1);
        chk("d0_restart_tt", b0.tt, 0);
        chk("d0_restart_mis_valid", W'(b0.mis_valid), 0);
        chk("d0_restart_match", W'(b0.match), 0);
        chk("d0_restart_x", W'(b0.x), 0);
        wait_done0(300);

        // Boundary minterms 0 and 127 both flipped: lowest wins.
        @(posedge clk); #1;
        start0(PAT ^ W'(1) ^ (W'(1) << 127), 1, 0, 1, 7'd0);
        wait_done0(300);

        // LAT=2 matching sweep with x sequence check.
        @(posedge clk); #1;
        xs.delete();
        start1(PAT, 1, 0, 0);
        wait_done1(300);
        chk("d1_xseq_len", W'(xs.size()), 130);
        nbad = 0;
        for (int i = 0; i < xs.size() && i < 130; i++)
            if (xs[i] != 7'((i < 128) ? i : 127)) nbad++;
        chk("d1_xseq_bad", W'(nbad), 0);

        // LAT=2, last minterm flipped: caught from the drain.
        @(posedge clk); #1;
        start1(PAT ^ (W'(1) << 127), 0, 1, 7'd127);
        wait_done1(300);

        // Start ignored while busy, then start+abort together: abort wins.
        @(posedge clk); #1;
        start0(PAT, 0, 0, 0, 0);
        repeat (39) @(posedge clk); #1;
        b0.start = 1'b1;
        @(posedge clk); #1;
        b0.start = 1'b0;
        chk("d0_ign_start_x", W'(b0.x), 40);
        chk("d0_ign_start_busy", W'(b0.busy), 1);
        repeat (19) @(posedge clk); #1;
        chk("d0_pre_abort_x", W'(b0.x), 59);
        b0.start = 1'b1; b0.abort = 1'b1;
        @(posedge clk); #1;
        b0.start = 1'b0; b0.abort = 1'b0;
        chk("d0_abort_x", W'(b0.x), 0);
        chk("d0_abort_busy", W'(b0.busy), 0);
        chk("d0_abort_tt", b0.tt, 0);
        repeat (150) @(posedge clk); #1;
        chk("d0_abort_idle_x", W'(b0.x), 0);

        // Reset mid-sweep, then a clean sweep.
        start0(PAT, 0, 0, 0, 0);
        repeat (49) @(posedge clk); #1;
        chk("d0_pre_rst_x", W'(b0.x), 49);
        rst_n = 1'b0;
        #1;
        check_reset("d0_mid", b0.x, b0.busy, b0.done, b0.match, b0.mis_valid, b0.mis_idx, b0.tt);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start0(PAT, 1, 1, 0, 0);
        wait_done0(300);

        repeat (5) @(posedge clk); #1;
        chk("d0_missing_done", W'(q0.size()), 0);
        chk("d1_missing_done", W'(q1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
